// File: rtl/sram_program_loader_if.sv
// Byte-stream handshake between a byte source (e.g. UART receiver) and the loader.
// A byte moves on every cycle where valid and ready are both high.
interface sram_program_loader_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sram_program_loader.sv
// Streams big-endian byte pairs into external 16-bit SRAM and holds the playback
// processor off the bus until the end instruction (top nibble 0000) is stored.
module sram_program_loader #(
  parameter int ADDR_W    = 18,
  parameter int MAX_WORDS = 262144,
  parameter int WE_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  sram_program_loader_if.slave  rx,
  output logic                  sram_we_o,
  output logic                  sram_ce_o,
  output logic                  sram_oe_o,
  output logic                  sram_lb_o,
  output logic                  sram_ub_o,
  output logic [ADDR_W-1:0]     sram_a_o,
  inout  wire  [15:0]           sram_dq_io,
  output logic                  busy_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_W-1:0]     word_count_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_SETUP = 3'd3,
    S_WRITE = 3'd4,
    S_HOLD  = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  localparam int                CNT_W     = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  WE_LAST   = CNT_W'(WE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         word_q, word_d;
  logic [CNT_W-1:0]    we_cnt_q, we_cnt_d;
  logic [ADDR_W-1:0]   wc_q, wc_d;

  logic                rx_ready_q, rx_ready_d;
  logic                we_n_q, we_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                dq_oe_q, dq_oe_d;
  logic [15:0]         dq_q;
  logic [ADDR_W-1:0]   sram_a_q, sram_a_d;
  logic                xfer_s;

  // rx_ready_q mirrors HI/LO state, so the handshake never depends on rx.valid combinationally
  assign xfer_s = rx.valid && rx_ready_q;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    we_cnt_d = we_cnt_q;
    wc_d     = wc_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_HI;
          addr_d  = {ADDR_W{1'b0}};
          wc_d    = {ADDR_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      S_HI: begin
        if (xfer_s) begin
          word_d[15:8] = rx.data;
          state_d      = S_LO;
        end else begin
          state_d = S_HI;
        end
      end
      S_LO: begin
        if (xfer_s) begin
          word_d[7:0] = rx.data;
          state_d     = S_SETUP;
        end else begin
          state_d = S_LO;
        end
      end
      S_SETUP: begin
        we_cnt_d = {CNT_W{1'b0}};
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (we_cnt_q == WE_LAST) begin
          state_d = S_HOLD;
        end else begin
          we_cnt_d = we_cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        wc_d = wc_q + ADDR_ONE;
        // An end instruction in the final slot still counts as a clean finish
        if (word_q[15:12] == 4'b0000) begin
          state_d = S_DONE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_ERROR;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = S_HI;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every pin comes straight from a flop
  always_comb begin
    busy_d     = 1'b0;
    rx_ready_d = 1'b0;
    we_n_d     = 1'b1;
    dq_oe_d    = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_d)
      S_HI, S_LO: begin
        busy_d     = 1'b1;
        rx_ready_d = 1'b1;
      end
      S_SETUP, S_HOLD: begin
        busy_d  = 1'b1;
        dq_oe_d = 1'b1;
      end
      S_WRITE: begin
        busy_d  = 1'b1;
        dq_oe_d = 1'b1;
        we_n_d  = 1'b0;
      end
      S_DONE:  done_d  = 1'b1;
      S_ERROR: error_d = 1'b1;
      default: busy_d  = 1'b0;
    endcase
    if (busy_d) begin
      sram_a_d = addr_d;
    end else begin
      sram_a_d = {ADDR_W{1'b0}};
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      word_q     <= 16'h0000;
      we_cnt_q   <= {CNT_W{1'b0}};
      wc_q       <= {ADDR_W{1'b0}};
      rx_ready_q <= 1'b0;
      we_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      dq_oe_q    <= 1'b0;
      dq_q       <= 16'h0000;
      sram_a_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      we_cnt_q   <= we_cnt_d;
      wc_q       <= wc_d;
      rx_ready_q <= rx_ready_d;
      we_n_q     <= we_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      dq_oe_q    <= dq_oe_d;
      dq_q       <= word_d;
      sram_a_q   <= sram_a_d;
    end
  end

  assign rx.ready     = rx_ready_q;
  assign sram_we_o    = we_n_q;
  assign sram_ce_o    = ~busy_q;
  assign sram_oe_o    = 1'b1;
  assign sram_lb_o    = ~busy_q;
  assign sram_ub_o    = ~busy_q;
  assign sram_a_o     = sram_a_q;
  assign sram_dq_io   = dq_oe_q ? dq_q : 16'hzzzz;
  assign busy_o       = busy_q;
  assign cpu_hold_o   = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign word_count_o = wc_q;

endmodule

// File: tb/tb_sram_program_loader.sv
// Scoreboard bench for sram_program_loader: expected SRAM writes are queued as
// words are streamed in and matched against each observed write strobe.
module tb_sram_program_loader;
  localparam int ADDR_W    = 18;
  localparam int MAX_WORDS = 4;
  localparam int WE_CYCLES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic we_n, ce_n, oe_n, lb_n, ub_n, busy, cpu_hold, done, error;
  logic [ADDR_W-1:0] sram_a, word_count;
  wire  [15:0] sram_dq;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [33:0] exp_q[$];
  logic [ADDR_W-1:0] tb_addr;

  sram_program_loader_if rx_if ();

  sram_program_loader #(
    .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .WE_CYCLES(WE_CYCLES)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rx(rx_if),
    .sram_we_o(we_n), .sram_ce_o(ce_n), .sram_oe_o(oe_n),
    .sram_lb_o(lb_n), .sram_ub_o(ub_n), .sram_a_o(sram_a),
    .sram_dq_io(sram_dq), .busy_o(busy), .cpu_hold_o(cpu_hold),
    .done_o(done), .error_o(error), .word_count_o(word_count)
  );

  always #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: measures each WE-low pulse and pops the scoreboard
  initial begin : monitor
    int low_cnt;
    logic [ADDR_W-1:0] cap_a;
    logic [15:0] cap_d;
    logic cap_oe;
    logic [33:0] e;
    low_cnt = 0;
    cap_a = '0;
    cap_d = '0;
    cap_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low_cnt = 0;
      end else if (!we_n) begin
        low_cnt++;
        cap_a  = sram_a;
        cap_d  = sram_dq;
        cap_oe = dut.dq_oe_q & ~ce_n & ~lb_n & ~ub_n;
      end else if (low_cnt != 0) begin
        check("we_low_cycles", low_cnt, WE_CYCLES);
        check("bus_driven_in_write", cap_oe, 1);
        check("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_addr", cap_a, e[33:16]);
          check("write_data", cap_d, e[15:0]);
        end
        low_cnt = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic got;
    got = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    rx_if.valid = 1'b1;
    rx_if.data  = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rx_if.ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      @(posedge clk); #1;
    end
    check("byte_accepted", got, 1);
    rx_if.valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int max_gap);
    exp_q.push_back({tb_addr, w});
    tb_addr = tb_addr + 1'b1;
    send_byte(w[15:8], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    send_byte(w[7:0],  (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
  endtask

  task automatic wait_idle();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    check("load_finished", got, 1);
  endtask

  task automatic idle_ready_probe(input logic [7:0] b, input string tag);
    logic seen;
    seen = 1'b0;
    rx_if.valid = 1'b1;
    rx_if.data  = b;
    repeat (8) begin
      @(negedge clk);
      seen = seen | rx_if.ready;
    end
    check(tag, seen, 0);
    rx_if.valid = 1'b0;
  endtask

  initial begin
    int t0;
    logic [15:0] prog[3];
    prog[0] = 16'h1060; prog[1] = 16'h8123; prog[2] = 16'h0000;
    rx_if.valid = 1'b0;
    rx_if.data  = 8'h00;
    tb_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_strobes", {we_n, ce_n, oe_n, lb_n, ub_n}, 5'b11111);
    check("rst_ready", rx_if.ready, 0);
    check("rst_addr", sram_a, 0);
    check("rst_dq_released", dut.dq_oe_q, 0);
    check("rst_status", {busy, cpu_hold, done, error}, 4'b0000);
    check("rst_word_count", word_count, 0);
    idle_ready_probe(8'h12, "ready_before_start");

    // Back-to-back program
    tb_addr = '0;
    pulse_start();
    t0 = cyc;
    check("start_busy_ready", {busy, cpu_hold, rx_if.ready}, 3'b111);
    check("start_bus_enables", {ce_n, oe_n, lb_n, ub_n}, 4'b0100);
    for (int i = 0; i < 3; i++) send_word(prog[i], 0);
    wait_idle();
    check("b2b_cycles", cyc - t0, 18);
    check("b2b_status", {done, error, busy, cpu_hold}, 4'b1000);
    check("b2b_word_count", word_count, 3);
    check("b2b_bus_released", {ce_n, lb_n, ub_n, dut.dq_oe_q}, 4'b1110);
    check("b2b_addr_idle", sram_a, 0);
    check("b2b_sb_drained", exp_q.size(), 0);

    // Same program with random gaps between bytes
    tb_addr = '0;
    pulse_start();
    check("gap_done_cleared", done, 0);
    for (int i = 0; i < 3; i++) send_word(prog[i], 5);
    wait_idle();
    check("gap_status", {done, error}, 2'b10);
    check("gap_word_count", word_count, 3);
    check("gap_sb_drained", exp_q.size(), 0);

    // Overflow: four non-end words fill the array
    tb_addr = '0;
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(16'h8000, 0);
    wait_idle();
    check("ovf_status", {done, error}, 2'b01);
    check("ovf_word_count", word_count, 4);
    check("ovf_sb_drained", exp_q.size(), 0);
    idle_ready_probe(8'h80, "ovf_fifth_refused");

    // End instruction in the last slot wins over overflow
    tb_addr = '0;
    pulse_start();
    check("restart_error_cleared", {error, busy}, 2'b01);
    for (int i = 0; i < 3; i++) send_word(16'h8000, 0);
    send_word(16'h0000, 0);
    wait_idle();
    check("last_end_status", {done, error}, 2'b10);
    check("last_end_word_count", word_count, 4);
    check("last_end_sb_drained", exp_q.size(), 0);

    // Reset during the write of word 1
    tb_addr = '0;
    pulse_start();
    send_word(16'h8111, 0);
    send_word(16'h8222, 0);
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!we_n) begin
          got = 1'b1;
          break;
        end
      end
      check("reached_write1", got, 1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_we", we_n, 1);
    check("rst_mid_dq_released", dut.dq_oe_q, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_status", {busy, done, error, rx_ready_sample()}, 4'b0000);
    check("post_rst_word_count", word_count, 0);
    tb_addr = '0;
    pulse_start();
    send_word(16'h0ABC, 0);
    wait_idle();
    check("reload_status", {done, error}, 2'b10);
    check("reload_word_count", word_count, 1);
    check("reload_sb_drained", exp_q.size(), 0);

    // START while busy is ignored; START after DONE restarts at 0
    tb_addr = '0;
    pulse_start();
    send_word(16'h8001, 0);
    pulse_start();
    check("busy_start_still_busy", busy, 1);
    send_word(16'h0002, 0);
    wait_idle();
    check("busy_start_status", {done, error}, 2'b10);
    check("busy_start_word_count", word_count, 2);
    check("busy_start_sb_drained", exp_q.size(), 0);
    tb_addr = '0;
    pulse_start();
    check("restart_cleared", {done, busy}, 2'b01);
    check("restart_word_count", word_count, 0);
    send_word(16'h0003, 0);
    wait_idle();
    check("restart_status", {done, error}, 2'b10);
    check("restart_final_count", word_count, 1);
    check("restart_sb_drained", exp_q.size(), 0);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  function automatic logic rx_ready_sample();
    return rx_if.ready;
  endfunction

endmodule

// File: doc/sram_program_loader.md
# sram_program_loader

Writes a music program into the external 16-bit SRAM from a byte stream, so the playback processor can later fetch and play it. Sits between a byte source (e.g. UART receiver) and the SRAM pins. Holds the processor off the bus while loading; releases it once the end instruction (top nibble 0000) is stored.

## Interface
- ADDR_W, 18: SRAM word-address width.
- MAX_WORDS, 262144: capacity in words; writing the last word without an end instruction is an overflow error.
- WE_CYCLES, 2: cycles SRAM_WE is held low per write (≥1).

- CLK  in  1  system clock (50 MHz); all logic on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle pulse; begins a load at address 0 from IDLE, DONE or ERROR; ignored while busy.
- RX_VALID  in  1  RX_DATA holds a byte.
- RX_DATA  in  8  incoming byte; words are big-endian (high byte first).
- RX_READY  out  1  loader accepts a byte this cycle; a transfer occurs when RX_VALID && RX_READY.
- SRAM_WE  out  1  active-low write enable.
- SRAM_CE  out  1  active-low chip enable.
- SRAM_OE  out  1  active-low output enable.
- SRAM_LB, SRAM_UB  out  1 each  active-low byte enables.
- SRAM_A  out  ADDR_W  word address.
- SRAM_DQ  inout  16  data bus; driven only in SETUP/WRITE/HOLD, else high-Z.
- BUSY  out  1  load in progress (states HI through HOLD).
- CPU_HOLD  out  1  equals BUSY; processor must not drive SRAM while high.
- DONE  out  1  end instruction stored; holds until next START or reset.
- ERROR  out  1  overflow; holds until next START or reset.
- WORD_COUNT  out  ADDR_W  words written in current/last load.

## Operation
- States: IDLE, HI, LO, SETUP, WRITE, HOLD, DONE, ERROR.
- IDLE/DONE/ERROR: START → HI; address and WORD_COUNT cleared to 0; DONE/ERROR cleared.
- HI: RX_READY=1; on transfer latch byte into word[15:8] → LO.
- LO: RX_READY=1; on transfer latch byte into word[7:0] → SETUP.
- SETUP: SRAM_A=address, SRAM_DQ driven with word, SRAM_WE=1; 1 cycle → WRITE.
- WRITE: SRAM_WE=0 for exactly WE_CYCLES cycles; A and DQ stable → HOLD.
- HOLD: SRAM_WE=1, A/DQ still driven, 1 cycle; WORD_COUNT increments. Then:
  - word[15:12]==4'b0000 → DONE (end instruction wins over overflow).
  - else if address==MAX_WORDS-1 → ERROR.
  - else address+1 → HI.
- Only data words are stored; no validity check on note/BPM encoding.
- SRAM_CE=0, SRAM_OE=1, SRAM_LB=SRAM_UB=0 while BUSY; in IDLE/DONE/ERROR CE=1, OE=1, LB=UB=1 and SRAM_A=0 so processor may own bus when CPU_HOLD=0.
- RX_VALID with RX_READY=0 is left pending; no byte dropped or consumed.

## Timing
- Reset (async assert, sync release): state IDLE, RX_READY=0, SRAM_WE=1, SRAM_CE=1, SRAM_OE=1, SRAM_LB=SRAM_UB=1, SRAM_A=0, SRAM_DQ high-Z, BUSY=CPU_HOLD=0, DONE=ERROR=0, WORD_COUNT=0.
- All outputs registered (or decoded from registered state); no combinational path RX_VALID→RX_READY.
- START at cycle t → BUSY and RX_READY high at t+1.
- Best-case word: 2 byte cycles + 1 SETUP + WE_CYCLES + 1 HOLD = 6 cycles at default; next HI begins cycle after HOLD.
- DONE/ERROR rise the cycle after HOLD, same cycle BUSY falls.
- Reset mid-write: WE returns to 1 and DQ releases immediately (asynchronously); partially written word is undefined.
- START during BUSY: ignored, no effect on state or counters.

## Test plan
- Reset then idle: all outputs at reset values; RX_VALID=1 with 0x12 → RX_READY stays 0 until START.
- START, stream 0x10,0x60,0x81,0x23,0x00,0x00 back-to-back → writes 0x1060@0, 0x8123@1, 0x0000@2; WE low exactly 2 cycles each; DONE=1, WORD_COUNT=3, BUSY=0.
- Gapped RX_VALID (random 0–5 idle cycles between bytes) → identical SRAM contents and word order as back-to-back case.
- MAX_WORDS=4, stream five 0x8000 words → 4 writes at 0–3, ERROR=1 after fourth HOLD, fifth byte pair never accepted (RX_READY=0); with fourth word 0x0000 instead → DONE, not ERROR.
- Assert RST_N=0 during WRITE of word 1 → WE=1, DQ high-Z same cycle; after release state IDLE, WORD_COUNT=0; new START reloads from address 0.
- START pulsed mid-load and again after DONE → first ignored; second restarts at address 0, DONE cleared, WORD_COUNT=0.
